// File: rtl/ov7670_fb_writer.sv
// rtl/ov7670_fb_writer.sv - OV7670 RGB565 byte-pair capture into a linear frame buffer
module ov7670_fb_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture_enable,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic [7:0]            cam_data,
    input  logic                  cam_byte_valid,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [15:0]           fb_data,
    output logic                  fb_we,
    output logic                  frame_done,
    output logic [7:0]            frame_count,
    output logic                  frame_error
);

    localparam logic [9:0]            H_RES_X = 10'(H_RES);
    localparam logic [9:0]            V_RES_Y = 10'(V_RES);
    localparam logic [ADDR_WIDTH-1:0] H_RES_A = ADDR_WIDTH'(H_RES);
    localparam logic [9:0]            CNT_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t                  state, next_state;
    logic                    vsync_d, href_d;
    logic                    phase;
    logic [7:0]              hi_byte;
    logic [9:0]              x, y;
    logic [9:0]              y_closed;
    logic [ADDR_WIDTH-1:0]   line_base;
    logic                    vs_fall, vs_rise, hr_fall;
    logic                    frame_start, frame_end, line_close, byte_take;

    assign vs_fall = vsync_d & ~cam_vsync;
    assign vs_rise = ~vsync_d & cam_vsync;
    assign hr_fall = href_d & ~cam_href;

    // Line close happens before the frame-end check, so the end-of-frame y test sees the closed line
    assign y_closed = (line_close && x != 10'd0 && y != CNT_MAX) ? y + 10'd1 : y;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_close  = 1'b0;
        byte_take   = 1'b0;
        case (state)
            IDLE: begin
                if (capture_enable) begin
                    next_state = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (!capture_enable) begin
                    next_state = IDLE;
                end else if (vs_fall) begin
                    next_state  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                line_close = hr_fall;
                byte_take  = cam_byte_valid & cam_href;
                if (vs_rise) begin
                    frame_end  = 1'b1;
                    next_state = capture_enable ? WAIT_VS : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Edge-detect history, pixel assembly, address generation and frame bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_d     <= 1'b0;
            href_d      <= 1'b0;
            phase       <= 1'b0;
            hi_byte     <= 8'd0;
            x           <= 10'd0;
            y           <= 10'd0;
            line_base   <= '0;
            fb_addr     <= '0;
            fb_data     <= 16'd0;
            fb_we       <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            frame_error <= 1'b0;
        end else begin
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                x         <= 10'd0;
                y         <= 10'd0;
                line_base <= '0;
                phase     <= 1'b0;
            end
            if (line_close) begin
                if (x != 10'd0) begin
                    if (y != CNT_MAX) begin
                        y <= y + 10'd1;
                    end
                    // line_base stops advancing past the last visible line so it never leaves the buffer
                    if (y < V_RES_Y) begin
                        line_base <= line_base + H_RES_A;
                    end
                end
                if (x != 10'd0 && x != H_RES_X) begin
                    frame_error <= 1'b1;
                end
                if (phase) begin
                    frame_error <= 1'b1;
                end
                x     <= 10'd0;
                phase <= 1'b0;
            end else if (byte_take) begin
                if (!phase) begin
                    hi_byte <= cam_data;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (x != CNT_MAX) begin
                        x <= x + 10'd1;
                    end
                    if (x < H_RES_X && y < V_RES_Y) begin
                        fb_we   <= 1'b1;
                        fb_addr <= line_base + ADDR_WIDTH'(x);
                        fb_data <= {hi_byte, cam_data};
                    end
                end
            end
            if (frame_end) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 8'd1;
                if (y_closed != V_RES_Y) begin
                    frame_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_fb_writer.sv
// tb/tb_ov7670_fb_writer.sv - self-checking bench for ov7670_fb_writer
module tb_ov7670_fb_writer;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          capture_enable;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          cam_byte_valid;
    logic [AW-1:0] fb_addr;
    logic [15:0]   fb_data;
    logic          fb_we;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          frame_error;

    ov7670_fb_writer #(.H_RES(H), .V_RES(V), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .capture_enable (capture_enable),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_data       (cam_data),
        .cam_byte_valid (cam_byte_valid),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .fb_we          (fb_we),
        .frame_done     (frame_done),
        .frame_count    (frame_count),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nl;
        int b0;
        int b1;
        int b2;
        int exp_writes;
        bit exp_err;
    } row_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t  sb[$];
    wr_t  got;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   exp_fc = 0;
    row_t rows[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (fb_we) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("spurious_we", 32'(fb_we), 32'd0);
            end else begin
                got = sb.pop_front();
                check("fb_addr", 32'(fb_addr), 32'(got.addr));
                check("fb_data", 32'(fb_data), 32'(got.data));
            end
        end
        if (frame_done) done_cnt++;
    end

    function automatic logic [7:0] pat(input int j);
        case (j)
            0: pat = 8'hF8;
            1: pat = 8'h00;
            2: pat = 8'h07;
            default: pat = 8'hE0;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit exp_we);
        cam_data       = b;
        cam_byte_valid = 1'b1;
        tick();
        check("we_latency", 32'(fb_we), 32'(exp_we));
        cam_byte_valid = 1'b0;
        tick();
    endtask

    task automatic send_line(input int l, input int nb, input bit cap);
        logic [7:0] hi, b;
        bit ok;
        hi = 8'd0;
        cam_href = 1'b1;
        tick();
        for (int j = 0; j < nb; j++) begin
            b  = (j < 4) ? pat(j) : 8'($urandom_range(0, 255));
            ok = 1'b0;
            if (j % 2 == 0) begin
                hi = b;
            end else if (cap && (j / 2) < H && l < V) begin
                ok = 1'b1;
                sb.push_back('{addr: AW'(l * H + j / 2), data: {hi, b}});
            end
            send_byte(b, ok);
        end
        cam_href = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_frame(input int nl, input int b0, input int b1, input int b2,
                             input bit cap, input int en_line, input bit en_val);
        cam_vsync = 1'b1;
        tick();
        tick();
        cam_vsync = 1'b0;
        tick();
        tick();
        for (int l = 0; l < nl; l++) begin
            if (l == en_line) capture_enable = en_val;
            send_line(l, (l == 0) ? b0 : (l == 1) ? b1 : b2, cap);
        end
        cam_vsync = 1'b1;
        tick();
        tick();
        tick();
        if (cap) exp_fc = (exp_fc + 1) % 256;
    endtask

    task automatic check_reset_outputs();
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
    endtask

    task automatic do_reset(input bit en);
        reset = 1'b1;
        tick();
        tick();
        check_reset_outputs();
        reset          = 1'b0;
        capture_enable = en;
        sb.delete();
        wr_cnt   = 0;
        done_cnt = 0;
        exp_fc   = 0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        capture_enable = 1'b0;
        cam_vsync      = 1'b0;
        cam_href       = 1'b0;
        cam_data       = 8'd0;
        cam_byte_valid = 1'b0;

        rows[0] = '{nl: 2, b0: 8,  b1: 8, b2: 0, exp_writes: 8, exp_err: 1'b0};
        rows[1] = '{nl: 2, b0: 12, b1: 8, b2: 0, exp_writes: 8, exp_err: 1'b1};
        rows[2] = '{nl: 2, b0: 7,  b1: 8, b2: 0, exp_writes: 7, exp_err: 1'b1};
        rows[3] = '{nl: 3, b0: 8,  b1: 8, b2: 8, exp_writes: 8, exp_err: 1'b1};
        rows[4] = '{nl: 1, b0: 8,  b1: 0, b2: 0, exp_writes: 4, exp_err: 1'b1};
        rows[5] = '{nl: 2, b0: 8,  b1: 6, b2: 0, exp_writes: 7, exp_err: 1'b1};

        for (int r = 0; r < 6; r++) begin
            do_reset(1'b1);
            run_frame(rows[r].nl, rows[r].b0, rows[r].b1, rows[r].b2, 1'b1, -1, 1'b1);
            check($sformatf("row%0d_writes", r), 32'(wr_cnt), 32'(rows[r].exp_writes));
            check($sformatf("row%0d_error", r), 32'(frame_error), 32'(rows[r].exp_err));
            check($sformatf("row%0d_count", r), 32'(frame_count), 32'(exp_fc));
            check($sformatf("row%0d_done", r), 32'(done_cnt), 32'd1);
            check($sformatf("row%0d_pending", r), 32'(sb.size()), 32'd0);
        end

        // Enable raised mid-frame: that frame is skipped, the next one starts at address 0
        do_reset(1'b0);
        run_frame(2, 8, 8, 0, 1'b0, 1, 1'b1);
        check("midena_writes", 32'(wr_cnt), 32'd0);
        check("midena_done", 32'(done_cnt), 32'd0);
        run_frame(2, 8, 8, 0, 1'b1, -1, 1'b1);
        check("midena_next_writes", 32'(wr_cnt), 32'd8);
        check("midena_next_count", 32'(frame_count), 32'(exp_fc));
        check("midena_pending", 32'(sb.size()), 32'd0);

        // Enable dropped during line 0: frame completes, next frame ignored
        do_reset(1'b1);
        run_frame(2, 8, 8, 0, 1'b1, 0, 1'b0);
        check("drop_writes", 32'(wr_cnt), 32'd8);
        check("drop_done", 32'(done_cnt), 32'd1);
        run_frame(2, 8, 8, 0, 1'b0, -1, 1'b0);
        check("drop_next_writes", 32'(wr_cnt), 32'd8);
        check("drop_next_done", 32'(done_cnt), 32'd1);
        check("drop_next_count", 32'(frame_count), 32'(exp_fc));

        // Reset in the middle of a line
        do_reset(1'b1);
        cam_vsync = 1'b1;
        tick();
        tick();
        cam_vsync = 1'b0;
        tick();
        tick();
        cam_href = 1'b1;
        tick();
        sb.push_back('{addr: AW'(0), data: 16'hF800});
        send_byte(8'hF8, 1'b0);
        send_byte(8'h00, 1'b1);
        sb.push_back('{addr: AW'(1), data: 16'h07E0});
        send_byte(8'h07, 1'b0);
        send_byte(8'hE0, 1'b1);
        reset = 1'b1;
        tick();
        check_reset_outputs();
        reset = 1'b0;
        for (int j = 0; j < 4; j++) send_byte(pat(j), 1'b0);
        cam_href = 1'b0;
        tick();
        tick();
        send_line(1, 8, 1'b0);
        cam_vsync = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_writes", 32'(wr_cnt), 32'd2);
        check("midrst_done", 32'(done_cnt), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        run_frame(2, 8, 8, 0, 1'b1, -1, 1'b1);
        check("midrst_next_writes", 32'(wr_cnt), 32'd10);
        check("midrst_next_error", 32'(frame_error), 32'd0);
        check("midrst_next_count", 32'(frame_count), 32'(exp_fc));

        // frame_count wrap with empty frames
        do_reset(1'b1);
        for (int f = 0; f < 255; f++) run_frame(0, 0, 0, 0, 1'b1, -1, 1'b1);
        check("wrap_255", 32'(frame_count), 32'd255);
        run_frame(0, 0, 0, 0, 1'b1, -1, 1'b1);
        check("wrap_0", 32'(frame_count), 32'(exp_fc));
        check("wrap_done", 32'(done_cnt), 32'd256);
        check("wrap_error", 32'(frame_error), 32'd1);
        check("wrap_writes", 32'(wr_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ov7670_fb_writer.md
Name: ov7670_fb_writer

Overview:
Capture-side writer for the camera frame buffer. It takes OV7670 byte-serial RGB565 pixel data and assembles each byte pair into a 16-bit pixel. It generates linear frame buffer addresses (y*H_RES + x) and issues single-cycle write strobes. Its output is the buffer image that the VGA display path reads back at 25 MHz.

Parameters:
H_RES, 640, active pixels per line; writes with x >= H_RES are dropped
V_RES, 480, active lines per frame; writes with y >= V_RES are dropped
ADDR_WIDTH, 19, frame buffer address width

Ports:
clk  input  1  system/pixel clock
reset  input  1  synchronous, active-high reset
capture_enable  input  1  level; 1 = capture frames
cam_vsync  input  1  camera VSYNC, already synchronized to clk; high = vertical blanking
cam_href  input  1  camera HREF, synchronized; high = active line
cam_data  input  8  camera byte, valid when cam_byte_valid=1
cam_byte_valid  input  1  one-cycle strobe per camera byte (PCLK edge sampled into clk domain)
fb_addr  output  ADDR_WIDTH  frame buffer write address
fb_data  output  16  RGB565 pixel, {first byte, second byte}
fb_we  output  1  one-cycle write strobe
frame_done  output  1  one-cycle pulse at end of each captured frame
frame_count  output  8  completed frames, wraps 255->0
frame_error  output  1  sticky geometry error flag

Behaviour:
- Reset: all outputs 0; state IDLE; x, y, line_base, byte phase, vsync_d and href_d all cleared. A reset mid-frame aborts the frame with no frame_done.
- Edge detection uses registered vsync_d and href_d. vs_fall = vsync_d & ~cam_vsync. vs_rise = ~vsync_d & cam_vsync. hr_fall = href_d & ~cam_href.
- FSM:
  - IDLE: capture_enable=1 -> WAIT_VS.
  - WAIT_VS: waits for cam_vsync=1 and then for vs_fall. A frame already in progress at enable is never captured.
  - On vs_fall -> ACTIVE. x=0, y=0, line_base=0, phase=0.
  - ACTIVE: vs_rise ends the frame. frame_done=1 for one cycle and frame_count increments. If y != V_RES, frame_error is set. Next state is WAIT_VS when capture_enable=1, otherwise IDLE.
  - capture_enable deasserted during ACTIVE: the current frame completes normally, then the FSM returns to IDLE.
- Pixel assembly (ACTIVE only, requires cam_byte_valid & cam_href):
  - phase 0: latch cam_data as the high byte; phase becomes 1.
  - phase 1: pixel = {hi, cam_data}; phase becomes 0; x increments (saturates at 2^10-1).
  - If x < H_RES and y < V_RES when the pixel forms: on the next cycle fb_we=1, fb_addr = line_base + x (pre-increment x), fb_data = pixel.
  - Write latency is 1 cycle after the second byte strobe. fb_addr and fb_data hold their values when fb_we=0.
- Bytes arriving with cam_href=0, or in any state other than ACTIVE, are ignored.
- Line close on hr_fall in ACTIVE:
  - If x != 0: y increments (saturating), line_base += H_RES, then x=0.
  - If x != H_RES and x != 0, frame_error is set.
  - If phase=1 (odd byte count), the dangling byte is discarded, phase returns to 0 and frame_error is set.
- Simultaneous hr_fall and vs_rise: the line close is applied first, so the y check at frame end uses the updated y.
- frame_error is cleared only by reset.
- Addresses never exceed H_RES*V_RES-1. No multiplier: addresses are formed incrementally from line_base.

Test Plan:
1. H_RES=4, V_RES=2; vsync pulse, then 2 lines of 8 bytes each (0xF8,0x00,0x07,0xE0,...) -> 8 writes at addr 0..7; first fb_data=0xF800, second 0x07E0; fb_we asserted 1 cycle after each second byte; frame_done pulses once; frame_count=1; frame_error=0.
2. Same configuration, one line carrying 6 pixels -> only addr 0..3 written for that line, next line starts at addr 4, frame_error=1.
3. Line with 7 bytes -> 3 writes, last byte dropped, frame_error=1, next line's first pixel assembled correctly.
4. capture_enable raised mid-frame with bytes flowing -> zero writes until after the next vs_fall; next frame writes from addr 0.
5. capture_enable dropped during line 0 -> frame completes (all 8 writes), frame_done pulses, FSM enters IDLE, following frame produces no writes and frame_count does not change.
6. Reset asserted mid-line -> next cycle all outputs 0, no frame_done; after release, data before the first vs_fall produces no writes. Also cover frame_count wrap: 256 frames gives frame_count=0.
